// File: rtl/data_mem_pkg.sv
// Shared address map, dump FSM state type and word type for the data-memory responder.
package data_mem_pkg;

   typedef logic [31:0] word_t;

   localparam word_t MMIO_BASE  = 32'h1000_0000;
   localparam word_t LED_OFS    = 32'h0000_0000;
   localparam word_t TIMER_OFS  = 32'h0000_0004;
   localparam word_t STATUS_OFS = 32'h0000_0008;

   typedef enum logic {IDLE, SEND} dump_state_t;

   // Byte lanes are ignored: only the word address takes part in decode.
   function automatic logic mmio_match(input word_t addr, input word_t ofs);
      return (addr & ~32'h3) == (MMIO_BASE | ofs);
   endfunction

endpackage

// File: rtl/data_mem_dump.sv
// Sequential RAM dump engine: streams RAM[0..DEPTH-1] over valid/ready using a
// snapshot register, forwarding a same-cycle CPU write to the word being loaded.
//
// state | meaning
// IDLE  | no dump; waiting for dump_start
// SEND  | dump_data holds snapshot of RAM[dump_addr], offered with dump_valid
module data_mem_dump
   import data_mem_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     dump_start,
   input  logic                     dump_ready,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_idx,
   input  word_t                    wr_data,
   output logic [$clog2(DEPTH)-1:0] rd_idx,
   input  word_t                    rd_data,
   output logic                     dump_busy,
   output logic                     dump_valid,
   output logic [$clog2(DEPTH)-1:0] dump_addr,
   output word_t                    dump_data
);

   localparam int IW = $clog2(DEPTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

   dump_state_t   state, state_nxt;
   logic [IW-1:0] idx, idx_nxt;
   word_t         data, data_nxt;
   logic          load;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         idx   <= '0;
         data  <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         data  <= data_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (dump_start) begin
               state_nxt = SEND;
               idx_nxt   = '0;
               load      = 1'b1;
            end
         end
         SEND: begin
            if (dump_ready) begin
               if (idx == LAST_IDX) begin
                  state_nxt = IDLE;
               end else begin
                  idx_nxt = idx + 1'b1;
                  load    = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      rd_idx   = idx_nxt;
      data_nxt = data;
      // The RAM still holds the old value during a write cycle, so take the write data instead.
      if (load) data_nxt = (wr_en && (wr_idx == idx_nxt)) ? wr_data : rd_data;
   end

   assign dump_busy  = (state == SEND);
   assign dump_valid = (state == SEND);
   assign dump_addr  = idx;
   assign dump_data  = data;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory bus responder: register-array RAM, LED/TIMER/STATUS MMIO and a RAM dump port.
// Define DATA_MEM_TIMER_EN to build the free-running TIMER register at MMIO_BASE+4.
module data_mem_responder
   import data_mem_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     WriteEnableMem,
   input  word_t                    AddressDataMem,
   input  word_t                    WriteDataMem,
   output word_t                    ReadData,
   output word_t                    led_reg,
   output logic                     addr_fault,
   input  logic                     dump_start,
   output logic                     dump_busy,
   output logic                     dump_valid,
   input  logic                     dump_ready,
   output logic [$clog2(DEPTH)-1:0] dump_addr,
   output word_t                    dump_data
);

   localparam int IW = $clog2(DEPTH);

   word_t         ram [DEPTH];
   logic [IW-1:0] cpu_idx;
   logic [IW-1:0] dump_rd_idx;
   logic          ram_hit, led_hit, timer_hit, status_hit, unmapped;
   logic          ram_we;

   // Upper-bit check covers both the [31:28]==0 region and the DEPTH bound.
   assign cpu_idx    = AddressDataMem[IW+1:2];
   assign ram_hit    = (AddressDataMem[31:IW+2] == '0);
   assign led_hit    = mmio_match(AddressDataMem, LED_OFS);
   assign status_hit = mmio_match(AddressDataMem, STATUS_OFS);
`ifdef DATA_MEM_TIMER_EN
   assign timer_hit  = mmio_match(AddressDataMem, TIMER_OFS);
`else
   assign timer_hit  = 1'b0;
`endif
   assign unmapped   = ~(ram_hit | led_hit | timer_hit | status_hit);
   assign ram_we     = WriteEnableMem & ram_hit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
      end else if (ram_we) begin
         ram[cpu_idx] <= WriteDataMem;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                         led_reg <= '0;
      else if (WriteEnableMem && led_hit) led_reg <= WriteDataMem;
   end

`ifdef DATA_MEM_TIMER_EN
   word_t timer;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                           timer <= '0;
      else if (WriteEnableMem && timer_hit) timer <= '0;
      else                                  timer <= timer + 32'd1;
   end
`endif

   // Every cycle presents an address, so an unmapped one faults even without a write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                             addr_fault <= 1'b0;
      else if (unmapped)                     addr_fault <= 1'b1;
      else if (WriteEnableMem && status_hit) addr_fault <= 1'b0;
   end

   always_comb begin
      ReadData = '0;
      if (ram_hit)         ReadData = ram[cpu_idx];
      else if (led_hit)    ReadData = led_reg;
`ifdef DATA_MEM_TIMER_EN
      else if (timer_hit)  ReadData = timer;
`endif
      else if (status_hit) ReadData = {30'b0, dump_busy, addr_fault};
   end

   data_mem_dump #(.DEPTH(DEPTH)) u_dump (
      .clk        (clk),
      .reset      (reset),
      .dump_start (dump_start),
      .dump_ready (dump_ready),
      .wr_en      (ram_we),
      .wr_idx     (cpu_idx),
      .wr_data    (WriteDataMem),
      .rd_idx     (dump_rd_idx),
      .rd_data    (ram[dump_rd_idx]),
      .dump_busy  (dump_busy),
      .dump_valid (dump_valid),
      .dump_addr  (dump_addr),
      .dump_data  (dump_data)
   );

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder end of the processor's data-memory bus. It accepts the word-wide WriteEnableMem/AddressDataMem/WriteDataMem requests and returns ReadData. It backs a register-array RAM plus a small memory-mapped I/O window (LED register, cycle timer, status), and adds a sequential dump engine that streams every RAM word out over a valid/ready handshake for LED/UART display. It sits beside ProcesadorARMv4 at the top level, in place of the single-register store.

## Interface
- DEPTH, 64 — number of 32-bit RAM words (power of two, 4..1024)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- WriteEnableMem  in  1  write strobe, sampled at clk edge
- AddressDataMem  in  32  byte address; bits [1:0] ignored
- WriteDataMem  in  32  write data
- ReadData  out  32  combinational read data for AddressDataMem
- led_reg  out  32  current LED register value
- addr_fault  out  1  sticky: access to unmapped/out-of-range address
- dump_start  in  1  one-cycle request to start a RAM dump
- dump_busy  out  1  dump in progress
- dump_valid  out  1  dump_data/dump_addr valid
- dump_ready  in  1  consumer accepts current word
- dump_addr  out  $clog2(DEPTH)  word index of dump_data
- dump_data  out  32  snapshot of RAM word

## Operation
- Address map:
  - RAM: AddressDataMem[31:28]==0 and word index AddressDataMem[31:2] < DEPTH; index = AddressDataMem[$clog2(DEPTH)+1:2].
  - 0x1000_0000 LED: read/write.
  - 0x1000_0004 TIMER: read; any write clears it.
  - 0x1000_0008 STATUS: read {30'b0, dump_busy, addr_fault}; any write clears addr_fault.
- Any other address: read 0, write ignored. addr_fault set at the clock edge if the access is a write, or if it is a read while WriteEnableMem=0 (every cycle counts as an access).
- TIMER: 32-bit, +1 per cycle, wraps 0xFFFF_FFFF→0. On a write cycle it loads 0, then resumes counting.
- addr_fault: set has priority over clear when both occur in the same cycle (not possible in a single access; documented for completeness).
- Dump FSM:
  - IDLE: dump_busy=0, dump_valid=0. When dump_start=1, go to SEND with idx=0 and dump_data loaded with RAM[0].
  - SEND: dump_busy=1, dump_valid=1. While dump_ready=0, dump_addr and dump_data stay stable, even if the CPU writes that word (snapshot). On dump_valid&&dump_ready: if idx==DEPTH-1, go to IDLE; otherwise idx+1 and load RAM[idx+1]. If the CPU writes word idx+1 in that same cycle, load WriteDataMem (forwarding).
  - dump_start while in SEND is ignored.
- Reset mid-dump: returns to IDLE immediately and clears all RAM, LED, TIMER and addr_fault.

## Timing
- Reset values: all outputs 0, RAM words 0, state IDLE.
- Reads: combinational, zero latency. A write becomes visible on ReadData the cycle after the edge. A read of the same address in the write cycle returns the old value.
- Dump: first word is valid the cycle after dump_start. At most one word per cycle with dump_ready held 1. A full dump takes DEPTH cycles. dump_busy falls the cycle after the final handshake.

## Configuration
- DATA_MEM_TIMER_EN defined: TIMER register is present as described.
- Not defined: no counter is built, and 0x1000_0004 is treated as unmapped: reads 0, writes ignored, addr_fault set.

## Structure
- Package data_mem_pkg holds:
  - address constants: MMIO_BASE=0x1000_0000, LED_OFS=0x0, TIMER_OFS=0x4, STATUS_OFS=0x8;
  - typedef enum logic {IDLE, SEND} dump_state_t;
  - typedef logic [31:0] word_t.
- One sub-module, data_mem_dump: dump FSM, index counter, snapshot register and write forwarding. It reads RAM through a word-index port and observes the CPU write port.

## Test plan
- Reset, write 0xDEADBEEF to 0x0000_0010, read 0x0000_0010 next cycle → ReadData=0xDEADBEEF. Same-cycle read → 0.
- Write 0x0000_00A5 to 0x1000_0000 → led_reg=0xA5 next cycle. Read 0x1000_0008 → 0. Read 0x2000_0000 → ReadData=0, then STATUS=1. Write STATUS → addr_fault=0.
- With DATA_MEM_TIMER_EN defined: read TIMER 10 cycles after reset release → 10; write TIMER → reads 1 one cycle later. Without the macro: read TIMER → 0 and addr_fault=1.
- Write address 4*DEPTH (out of range) → RAM unchanged, addr_fault=1.
- Preload RAM[i]=i+0x100, pulse dump_start, hold dump_ready=1 → DEPTH transfers, dump_addr 0..DEPTH-1, data i+0x100, dump_busy low after last. Toggle dump_ready randomly → same sequence with no loss or duplication.
- During a dump with dump_ready=0 at idx 3, CPU writes RAM[3]=0x55 → dump_data unchanged. In the handshake cycle for idx 3, CPU writes RAM[4]=0x77 → next dump_data=0x77. Assert reset mid-dump → dump_busy=0, dump_valid=0, RAM reads 0.
